// File: rtl/ctrl_pipe.sv
// Control-signal pipeline for the RV32 core: carries decoded controls ID->EX->MEM->WB,
// inserts load-use bubbles, squashes wrong-path work on taken branches and freezes on mem_busy.
module ctrl_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_branch,
  input  logic             id_memread,
  input  logic             id_memtoreg,
  input  logic             id_memwrite,
  input  logic             id_alusrc,
  input  logic             id_regwrite,
  input  logic             id_i_type,
  input  logic             id_lui_flag,
  input  logic [1:0]       id_aluop,
  input  logic [1:0]       id_aj_control,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             ex_taken,
  input  logic             mem_busy,
  output logic             stall,
  output logic             flush_ifid,
  output logic             ex_valid,
  output logic             ex_branch,
  output logic             ex_memread,
  output logic             ex_memtoreg,
  output logic             ex_memwrite,
  output logic             ex_alusrc,
  output logic             ex_regwrite,
  output logic             ex_i_type,
  output logic             ex_lui_flag,
  output logic [1:0]       ex_aluop,
  output logic [1:0]       ex_aj_control,
  output logic [4:0]       ex_rd,
  output logic             mem_valid,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic             mem_memtoreg,
  output logic             mem_regwrite,
  output logic [1:0]       mem_aj_control,
  output logic [4:0]       mem_rd,
  output logic             wb_valid,
  output logic             wb_memtoreg,
  output logic             wb_regwrite,
  output logic [1:0]       wb_aj_control,
  output logic [4:0]       wb_rd,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_STALL,
    MODE_FLUSH,
    MODE_FREEZE
  } mode_t;

  typedef struct packed {
    logic       valid;
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic       i_type;
    logic       lui_flag;
    logic [1:0] aluop;
    logic [1:0] aj_control;
    logic [4:0] rd;
  } ex_stage_t;

  typedef struct packed {
    logic       valid;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic [1:0] aj_control;
    logic [4:0] rd;
  } mem_stage_t;

  typedef struct packed {
    logic       valid;
    logic       memtoreg;
    logic       regwrite;
    logic [1:0] aj_control;
    logic [4:0] rd;
  } wb_stage_t;

  ex_stage_t  ex_q, ex_next, id_bundle;
  mem_stage_t mem_q, mem_next;
  wb_stage_t  wb_q, wb_next;
  mode_t      mode;
  logic       rs1_used, rs2_used, load_use;

  // jal is deliberately not excluded from rs1 use: a spurious stall is cheaper than a missed hazard
  always_comb begin
    rs1_used = !(id_lui_flag || (id_aj_control == 2'b11));
    rs2_used = !id_alusrc || id_memwrite;
    load_use = ex_q.valid && ex_q.memread && (ex_q.rd != 5'd0) && id_valid &&
               ((rs1_used && (id_rs1 == ex_q.rd)) || (rs2_used && (id_rs2 == ex_q.rd)));
    mode = MODE_RUN;
    if (mem_busy)
      mode = MODE_FREEZE;
    else if (ex_taken && ex_q.valid)
      mode = MODE_FLUSH;
    else if (load_use)
      mode = MODE_STALL;
    stall      = rst && ((mode == MODE_FREEZE) || (mode == MODE_STALL));
    flush_ifid = rst && (mode == MODE_FLUSH);
  end

  always_comb begin
    id_bundle            = '0;
    id_bundle.valid      = id_valid;
    id_bundle.branch     = id_branch;
    id_bundle.memread    = id_memread;
    id_bundle.memtoreg   = id_memtoreg;
    id_bundle.memwrite   = id_memwrite;
    id_bundle.alusrc     = id_alusrc;
    id_bundle.regwrite   = id_regwrite;
    id_bundle.i_type     = id_i_type;
    id_bundle.lui_flag   = id_lui_flag;
    id_bundle.aluop      = id_aluop;
    id_bundle.aj_control = id_aj_control;
    id_bundle.rd         = id_rd;
    ex_next = ((mode == MODE_RUN) && id_valid) ? id_bundle : '0;

    mem_next            = '0;
    mem_next.valid      = ex_q.valid;
    mem_next.memread    = ex_q.valid && ex_q.memread;
    mem_next.memwrite   = ex_q.valid && ex_q.memwrite;
    mem_next.memtoreg   = ex_q.memtoreg;
    mem_next.regwrite   = ex_q.valid && ex_q.regwrite;
    mem_next.aj_control = ex_q.aj_control;
    mem_next.rd         = ex_q.rd;

    wb_next            = '0;
    wb_next.valid      = mem_q.valid;
    wb_next.memtoreg   = mem_q.memtoreg;
    wb_next.regwrite   = mem_q.valid && mem_q.regwrite;
    wb_next.aj_control = mem_q.aj_control;
    wb_next.rd         = mem_q.rd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (mode != MODE_FREEZE) begin
      ex_q  <= ex_next;
      mem_q <= mem_next;
      wb_q  <= wb_next;
    end
  end

  // Debug counters stick at all-ones rather than wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if ((mode == MODE_STALL) && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
      if ((mode == MODE_FLUSH) && (flush_count != {CNT_W{1'b1}}))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

  assign ex_valid       = ex_q.valid;
  assign ex_branch      = ex_q.branch;
  assign ex_memread     = ex_q.valid && ex_q.memread;
  assign ex_memtoreg    = ex_q.memtoreg;
  assign ex_memwrite    = ex_q.valid && ex_q.memwrite;
  assign ex_alusrc      = ex_q.alusrc;
  assign ex_regwrite    = ex_q.valid && ex_q.regwrite;
  assign ex_i_type      = ex_q.i_type;
  assign ex_lui_flag    = ex_q.lui_flag;
  assign ex_aluop       = ex_q.aluop;
  assign ex_aj_control  = ex_q.aj_control;
  assign ex_rd          = ex_q.rd;

  assign mem_valid      = mem_q.valid;
  assign mem_memread    = mem_q.valid && mem_q.memread;
  assign mem_memwrite   = mem_q.valid && mem_q.memwrite;
  assign mem_memtoreg   = mem_q.memtoreg;
  assign mem_regwrite   = mem_q.valid && mem_q.regwrite;
  assign mem_aj_control = mem_q.aj_control;
  assign mem_rd         = mem_q.rd;

  assign wb_valid       = wb_q.valid;
  assign wb_memtoreg    = wb_q.memtoreg;
  assign wb_regwrite    = wb_q.valid && wb_q.regwrite;
  assign wb_aj_control  = wb_q.aj_control;
  assign wb_rd          = wb_q.rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: accepted instructions are queued at issue and
// retired against the WB stage; per-scenario tasks check hazards, flushes and freezes.
module tb_ctrl_pipe;

  localparam int TB_CNT_W = 4;
  localparam int SAT_MAX  = (1 << TB_CNT_W) - 1;

  typedef struct packed {
    logic       valid;
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic       i_type;
    logic       lui_flag;
    logic [1:0] aluop;
    logic [1:0] aj;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } instr_t;

  typedef struct packed {
    logic       memtoreg;
    logic       regwrite;
    logic [1:0] aj;
    logic [4:0] rd;
  } wb_exp_t;

  logic clk, rst;
  logic id_valid, id_branch, id_memread, id_memtoreg, id_memwrite;
  logic id_alusrc, id_regwrite, id_i_type, id_lui_flag;
  logic [1:0] id_aluop, id_aj_control;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic ex_taken, mem_busy;
  logic stall, flush_ifid;
  logic ex_valid, ex_branch, ex_memread, ex_memtoreg, ex_memwrite;
  logic ex_alusrc, ex_regwrite, ex_i_type, ex_lui_flag;
  logic [1:0] ex_aluop, ex_aj_control;
  logic [4:0] ex_rd;
  logic mem_valid, mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite;
  logic [1:0] mem_aj_control;
  logic [4:0] mem_rd;
  logic wb_valid, wb_memtoreg, wb_regwrite;
  logic [1:0] wb_aj_control;
  logic [4:0] wb_rd;
  logic [TB_CNT_W-1:0] stall_count, flush_count;
  logic [42+2*TB_CNT_W-1:0] all_out;

  int checks = 0;
  int failures = 0;
  wb_exp_t exp_q[$];
  wb_exp_t mon_e;
  logic mon_rst, mon_busy;

  ctrl_pipe #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_branch(id_branch), .id_memread(id_memread),
    .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite), .id_alusrc(id_alusrc),
    .id_regwrite(id_regwrite), .id_i_type(id_i_type), .id_lui_flag(id_lui_flag),
    .id_aluop(id_aluop), .id_aj_control(id_aj_control),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_taken(ex_taken), .mem_busy(mem_busy),
    .stall(stall), .flush_ifid(flush_ifid),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_memread(ex_memread),
    .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc),
    .ex_regwrite(ex_regwrite), .ex_i_type(ex_i_type), .ex_lui_flag(ex_lui_flag),
    .ex_aluop(ex_aluop), .ex_aj_control(ex_aj_control), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_memtoreg(mem_memtoreg), .mem_regwrite(mem_regwrite),
    .mem_aj_control(mem_aj_control), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite),
    .wb_aj_control(wb_aj_control), .wb_rd(wb_rd),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  assign all_out = {stall, flush_ifid,
                    ex_valid, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc,
                    ex_regwrite, ex_i_type, ex_lui_flag, ex_aluop, ex_aj_control, ex_rd,
                    mem_valid, mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite,
                    mem_aj_control, mem_rd,
                    wb_valid, wb_memtoreg, wb_regwrite, wb_aj_control, wb_rd,
                    stall_count, flush_count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic instr_t mk_nop();
    instr_t i = '0;
    return i;
  endfunction

  function automatic instr_t mk_lw(input logic [4:0] rd, input logic [4:0] rs1);
    instr_t i = '0;
    i.valid = 1; i.memread = 1; i.memtoreg = 1; i.regwrite = 1; i.alusrc = 1; i.i_type = 1;
    i.rs1 = rs1; i.rd = rd;
    return i;
  endfunction

  function automatic instr_t mk_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    instr_t i = '0;
    i.valid = 1; i.regwrite = 1; i.aluop = 2'b10; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
    return i;
  endfunction

  function automatic instr_t mk_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2f);
    instr_t i = '0;
    i.valid = 1; i.regwrite = 1; i.alusrc = 1; i.i_type = 1; i.aluop = 2'b10;
    i.rs1 = rs1; i.rs2 = rs2f; i.rd = rd;
    return i;
  endfunction

  function automatic instr_t mk_lui(input logic [4:0] rd, input logic [4:0] junk);
    instr_t i = '0;
    i.valid = 1; i.regwrite = 1; i.alusrc = 1; i.lui_flag = 1; i.rs1 = junk; i.rs2 = junk; i.rd = rd;
    return i;
  endfunction

  function automatic instr_t mk_sw(input logic [4:0] rs1, input logic [4:0] rs2);
    instr_t i = '0;
    i.valid = 1; i.memwrite = 1; i.alusrc = 1; i.rs1 = rs1; i.rs2 = rs2;
    return i;
  endfunction

  function automatic instr_t mk_beq(input logic [4:0] rs1, input logic [4:0] rs2);
    instr_t i = '0;
    i.valid = 1; i.branch = 1; i.aluop = 2'b01; i.rs1 = rs1; i.rs2 = rs2;
    return i;
  endfunction

  // Drives one ID-stage cycle just after the edge and returns at the following negedge
  task automatic apply_stimulus(input instr_t ins, input bit accepted, input bit taken, input bit busy);
    wb_exp_t e;
    @(posedge clk);
    #1;
    id_valid = ins.valid; id_branch = ins.branch; id_memread = ins.memread;
    id_memtoreg = ins.memtoreg; id_memwrite = ins.memwrite; id_alusrc = ins.alusrc;
    id_regwrite = ins.regwrite; id_i_type = ins.i_type; id_lui_flag = ins.lui_flag;
    id_aluop = ins.aluop; id_aj_control = ins.aj;
    id_rs1 = ins.rs1; id_rs2 = ins.rs2; id_rd = ins.rd;
    ex_taken = taken; mem_busy = busy;
    if (accepted && ins.valid) begin
      e.memtoreg = ins.memtoreg; e.regwrite = ins.regwrite; e.aj = ins.aj; e.rd = ins.rd;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    ex_taken = 0; mem_busy = 0; id_valid = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain(input string name);
    repeat (4) apply_stimulus(mk_nop(), 0, 0, 0);
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("[TB] FAIL %s_drain pending=%0d expected=0", name, exp_q.size());
    end
  endtask

  // WB retirement scoreboard; frozen and reset edges retire nothing
  always @(posedge clk) begin
    mon_rst  = rst;
    mon_busy = mem_busy;
    #1;
    if (mon_rst && rst && !mon_busy && wb_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL wb_unexpected got rd=%0d expected=none", wb_rd);
      end else begin
        mon_e = exp_q.pop_front();
        if ({wb_memtoreg, wb_regwrite, wb_aj_control, wb_rd} !== mon_e) begin
          failures++;
          $display("[TB] FAIL wb_retire got=%h expected=%h",
                   {wb_memtoreg, wb_regwrite, wb_aj_control, wb_rd}, mon_e);
        end
      end
    end
  end

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      id_valid = 1; id_memread = 1; id_regwrite = 1; id_rd = 5'd5; id_rs1 = 5'd5;
      ex_taken = i[0]; mem_busy = i[1];
      @(negedge clk);
      checks++;
      if (all_out !== '0) begin
        failures++;
        $display("[TB] FAIL reset_outputs got=%h expected=0", all_out);
      end
    end
    rst = 1'b1; id_valid = 0; ex_taken = 0; mem_busy = 0;
    apply_stimulus(mk_lw(5'd5, 5'd1), 1, 0, 0);
    apply_stimulus(mk_nop(), 0, 0, 0);
    checks++;
    if ({ex_valid, ex_memread, ex_regwrite, ex_rd} !== {3'b111, 5'd5}) begin
      failures++;
      $display("[TB] FAIL reset_lw_ex got=%b expected=%b", {ex_valid, ex_memread, ex_regwrite, ex_rd}, {3'b111, 5'd5});
    end
    apply_stimulus(mk_nop(), 0, 0, 0);
    checks++;
    if ({mem_valid, mem_memread, mem_regwrite, mem_rd, ex_valid} !== {3'b111, 5'd5, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_lw_mem got=%b expected=%b", {mem_valid, mem_memread, mem_regwrite, mem_rd, ex_valid}, {3'b111, 5'd5, 1'b0});
    end
    apply_stimulus(mk_nop(), 0, 0, 0);
    checks++;
    if ({wb_valid, wb_memtoreg, wb_regwrite, wb_rd} !== {3'b111, 5'd5}) begin
      failures++;
      $display("[TB] FAIL reset_lw_wb got=%b expected=%b", {wb_valid, wb_memtoreg, wb_regwrite, wb_rd}, {3'b111, 5'd5});
    end
    drain("reset");
  endtask

  task automatic test_load_use();
    do_reset();
    apply_stimulus(mk_lw(5'd5, 5'd1), 1, 0, 0);
    apply_stimulus(mk_add(5'd6, 5'd5, 5'd2), 0, 0, 0);
    checks++;
    if ({stall, flush_ifid} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL lu_stall got=%b expected=10", {stall, flush_ifid});
    end
    apply_stimulus(mk_add(5'd6, 5'd5, 5'd2), 1, 0, 0);
    checks++;
    if ({ex_valid, stall} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL lu_bubble got=%b expected=00", {ex_valid, stall});
    end
    apply_stimulus(mk_nop(), 0, 0, 0);
    checks++;
    if ({ex_valid, ex_regwrite, ex_rd, stall_count} !== {2'b11, 5'd6, 4'd1}) begin
      failures++;
      $display("[TB] FAIL lu_resume got=%b expected=%b", {ex_valid, ex_regwrite, ex_rd, stall_count}, {2'b11, 5'd6, 4'd1});
    end
    apply_stimulus(mk_lw(5'd0, 5'd1), 1, 0, 0);
    apply_stimulus(mk_add(5'd7, 5'd0, 5'd0), 1, 0, 0);
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL lu_rd0_stall got=%b expected=0", stall);
    end
    apply_stimulus(mk_nop(), 0, 0, 0);
    checks++;
    if ({ex_valid, ex_rd, stall_count} !== {1'b1, 5'd7, 4'd1}) begin
      failures++;
      $display("[TB] FAIL lu_rd0_ex got=%b expected=%b", {ex_valid, ex_rd, stall_count}, {1'b1, 5'd7, 4'd1});
    end
    drain("load_use");
  endtask

  task automatic test_branch_flush();
    do_reset();
    apply_stimulus(mk_beq(5'd1, 5'd2), 1, 0, 0);
    apply_stimulus(mk_add(5'd8, 5'd3, 5'd4), 0, 1, 0);
    checks++;
    if ({flush_ifid, stall} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL br_flush got=%b expected=10", {flush_ifid, stall});
    end
    apply_stimulus(mk_nop(), 0, 0, 0);
    checks++;
    if ({ex_valid, mem_valid, mem_regwrite, flush_count} !== {3'b010, 4'd1}) begin
      failures++;
      $display("[TB] FAIL br_squash got=%b expected=%b", {ex_valid, mem_valid, mem_regwrite, flush_count}, {3'b010, 4'd1});
    end
    apply_stimulus(mk_lw(5'd9, 5'd1), 1, 0, 0);
    apply_stimulus(mk_add(5'd10, 5'd9, 5'd2), 0, 1, 0);
    checks++;
    if ({flush_ifid, stall} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL br_lu_priority got=%b expected=10", {flush_ifid, stall});
    end
    apply_stimulus(mk_nop(), 0, 0, 0);
    checks++;
    if ({ex_valid, mem_memread, flush_count, stall_count} !== {2'b01, 4'd2, 4'd0}) begin
      failures++;
      $display("[TB] FAIL br_lu_counts got=%b expected=%b", {ex_valid, mem_memread, flush_count, stall_count}, {2'b01, 4'd2, 4'd0});
    end
    drain("branch");
    apply_stimulus(mk_nop(), 0, 1, 0);
    checks++;
    if (flush_ifid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL br_invalid_taken got=%b expected=0", flush_ifid);
    end
    apply_stimulus(mk_nop(), 0, 0, 0);
    checks++;
    if (flush_count !== 4'd2) begin
      failures++;
      $display("[TB] FAIL br_invalid_count got=%0d expected=2", flush_count);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    apply_stimulus(mk_lw(5'd10, 5'd1), 1, 0, 0);
    apply_stimulus(mk_add(5'd11, 5'd1, 5'd2), 1, 0, 0);
    apply_stimulus(mk_addi(5'd12, 5'd3, 5'd0), 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(mk_sw(5'd3, 5'd4), 0, 0, 1);
      checks++;
      if ({stall, ex_rd, mem_rd, wb_rd, stall_count, flush_count} !== {1'b1, 5'd12, 5'd11, 5'd10, 8'd0}) begin
        failures++;
        $display("[TB] FAIL freeze_hold cycle=%0d got=%b expected=%b", i,
                 {stall, ex_rd, mem_rd, wb_rd, stall_count, flush_count}, {1'b1, 5'd12, 5'd11, 5'd10, 8'd0});
      end
    end
    apply_stimulus(mk_sw(5'd3, 5'd4), 1, 0, 0);
    checks++;
    if ({stall, ex_rd, wb_rd} !== {1'b0, 5'd12, 5'd10}) begin
      failures++;
      $display("[TB] FAIL freeze_release got=%b expected=%b", {stall, ex_rd, wb_rd}, {1'b0, 5'd12, 5'd10});
    end
    apply_stimulus(mk_nop(), 0, 0, 0);
    checks++;
    if ({ex_memwrite, mem_rd, wb_rd, stall_count, flush_count} !== {1'b1, 5'd12, 5'd11, 8'd0}) begin
      failures++;
      $display("[TB] FAIL freeze_resume got=%b expected=%b", {ex_memwrite, mem_rd, wb_rd, stall_count, flush_count}, {1'b1, 5'd12, 5'd11, 8'd0});
    end
    drain("freeze");
  endtask

  task automatic test_saturation();
    int exp_cnt;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(mk_lw(5'd5, 5'd1), 1, 0, 0);
      apply_stimulus(mk_add(5'd6, 5'd5, 5'd5), 0, 0, 0);
      apply_stimulus(mk_add(5'd6, 5'd5, 5'd5), 1, 0, 0);
      exp_cnt = (i + 1 > SAT_MAX) ? SAT_MAX : i + 1;
      checks++;
      if (int'(stall_count) !== exp_cnt) begin
        failures++;
        $display("[TB] FAIL sat_count iter=%0d got=%0d expected=%0d", i, stall_count, exp_cnt);
      end
    end
    drain("saturation");
  endtask

  task automatic test_operand_gating();
    do_reset();
    apply_stimulus(mk_lw(5'd7, 5'd1), 1, 0, 0);
    apply_stimulus(mk_addi(5'd8, 5'd1, 5'd7), 1, 0, 0);
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL gate_addi_rs2 got=%b expected=0", stall);
    end
    apply_stimulus(mk_lw(5'd7, 5'd1), 1, 0, 0);
    apply_stimulus(mk_lui(5'd9, 5'd7), 1, 0, 0);
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL gate_lui_rs1 got=%b expected=0", stall);
    end
    apply_stimulus(mk_lw(5'd7, 5'd1), 1, 0, 0);
    apply_stimulus(mk_sw(5'd2, 5'd7), 0, 0, 0);
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL gate_sw_rs2 got=%b expected=1", stall);
    end
    apply_stimulus(mk_sw(5'd2, 5'd7), 1, 0, 0);
    apply_stimulus(mk_nop(), 0, 0, 0);
    checks++;
    if ({ex_valid, ex_memwrite, stall_count} !== {2'b11, 4'd1}) begin
      failures++;
      $display("[TB] FAIL gate_sw_ex got=%b expected=%b", {ex_valid, ex_memwrite, stall_count}, {2'b11, 4'd1});
    end
    drain("gating");
  endtask

  initial begin
    rst = 1'b0;
    id_valid = 0; id_branch = 0; id_memread = 0; id_memtoreg = 0; id_memwrite = 0;
    id_alusrc = 0; id_regwrite = 0; id_i_type = 0; id_lui_flag = 0;
    id_aluop = 0; id_aj_control = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    ex_taken = 0; mem_busy = 0;
    test_reset();
    test_load_use();
    test_branch_flush();
    test_freeze();
    test_saturation();
    test_operand_gating();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
